riscv_register_file_sb: RTL and testbench

Parametrised register file for the RI5CY-class core with a configurable number of read ports, an optional FP bank, and an integrated per-register scoreboard. The scoreboard tracks registers reserved by long-latency units (LSU, FPU, dividers) until their write-back lands. It sits in the ID stage. The decoder reserves destinations and polls busy flags per read port to generate operand stalls. The EX/WB stages drive the two write ports.

---
 rtl/riscv_register_file_sb.sv | 110 +++++++++++
 tb/tb_riscv_register_file_sb.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/riscv_register_file_sb.sv
// Register file with an integer bank, an optional FP bank and a per-register
// busy scoreboard for long-latency destinations.
// Read ports are combinational. Writes, reservations and the busy count update on the rising edge.
// No stalls inside: rsv_ready_o refuses a reservation when the target word is already busy.
// Ports: clk/rst_n (sync active-low), setback_i (sync clear), raddr_i/rdata_o/rbusy_o
//   (NUM_RPORTS packed read ports), write ports A (ALU) and B (long-latency write-back),
//   rsv_addr_i/rsv_valid_i/rsv_ready_o (destination reservation), pending_cnt_o (busy popcount).
// Optional macro RF_WRITE_BYPASS_EN: forward same-cycle write data to the read ports.
module riscv_register_file_sb #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int FPU        = 0,
  parameter int ZFINX      = 0,
  parameter int NUM_RPORTS = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             setback_i,
  input  logic [NUM_RPORTS*ADDR_WIDTH-1:0] raddr_i,
  output logic [NUM_RPORTS*DATA_WIDTH-1:0] rdata_o,
  output logic [NUM_RPORTS-1:0]            rbusy_o,
  input  logic [ADDR_WIDTH-1:0]            waddr_a_i,
  input  logic [DATA_WIDTH-1:0]            wdata_a_i,
  input  logic                             we_a_i,
  input  logic [ADDR_WIDTH-1:0]            waddr_b_i,
  input  logic [DATA_WIDTH-1:0]            wdata_b_i,
  input  logic                             we_b_i,
  input  logic [ADDR_WIDTH-1:0]            rsv_addr_i,
  input  logic                             rsv_valid_i,
  output logic                             rsv_ready_o,
  output logic [ADDR_WIDTH:0]              pending_cnt_o
);

  localparam bit HAS_FP    = (FPU == 1) && (ZFINX == 0);
  localparam int NUM_SLOTS = 2 ** ADDR_WIDTH;

  // Storage is indexed by the full address. Without an FP bank the MSB is
  // folded away, so the upper half is never written and trims out in synthesis.
  // Slot 0 is integer x0: never written, never reserved, so it reads 0 forever.
  logic [DATA_WIDTH-1:0] mem_q [NUM_SLOTS];
  logic [DATA_WIDTH-1:0] mem_d [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]  busy_q, busy_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;

  logic [ADDR_WIDTH-1:0] wa_idx, wb_idx, rsv_idx;

  function automatic logic [ADDR_WIDTH-1:0] map_addr(input logic [ADDR_WIDTH-1:0] a);
    return HAS_FP ? a : {1'b0, a[ADDR_WIDTH-2:0]};
  endfunction

  assign wa_idx  = map_addr(waddr_a_i);
  assign wb_idx  = map_addr(waddr_b_i);
  assign rsv_idx = map_addr(rsv_addr_i);

  assign rsv_ready_o   = rsv_valid_i & ~busy_q[rsv_idx];
  assign pending_cnt_o = cnt_q;

  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    cnt_d  = '0;
    if (setback_i) begin
      for (int i = 0; i < NUM_SLOTS; i++) mem_d[i] = '0;
      busy_d = '0;
    end else begin
      // Port B is applied after port A so it wins a same-address collision.
      if (we_a_i && (wa_idx != '0)) mem_d[wa_idx] = wdata_a_i;
      if (we_b_i && (wb_idx != '0)) begin
        mem_d[wb_idx]  = wdata_b_i;
        busy_d[wb_idx] = 1'b0;
      end
      // Reservation applied last: a write-back landing on a word that is being
      // reserved in the same cycle leaves the new reservation standing.
      if (rsv_ready_o && (rsv_idx != '0)) busy_d[rsv_idx] = 1'b1;
    end
    for (int i = 0; i < NUM_SLOTS; i++) cnt_d = cnt_d + (ADDR_WIDTH+1)'(busy_d[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) mem_q[i] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) mem_q[i] <= mem_d[i];
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    rdata_o = '0;
    rbusy_o = '0;
    for (int k = 0; k < NUM_RPORTS; k++) begin
      rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[map_addr(raddr_i[k*ADDR_WIDTH +: ADDR_WIDTH])];
      rbusy_o[k] = busy_q[map_addr(raddr_i[k*ADDR_WIDTH +: ADDR_WIDTH])];
`ifdef RF_WRITE_BYPASS_EN
      if (map_addr(raddr_i[k*ADDR_WIDTH +: ADDR_WIDTH]) != '0) begin
        if (we_b_i && (wb_idx == map_addr(raddr_i[k*ADDR_WIDTH +: ADDR_WIDTH]))) begin
          rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = wdata_b_i;
          rbusy_o[k] = 1'b0;
        end else if (we_a_i && (wa_idx == map_addr(raddr_i[k*ADDR_WIDTH +: ADDR_WIDTH]))) begin
          rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = wdata_a_i;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_riscv_register_file_sb.sv
module tb_riscv_register_file_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        setback;
  logic [17:0] raddr;
  logic [95:0] rdata;
  logic [2:0]  rbusy;
  logic [5:0]  waddr_a, waddr_b, rsv_addr;
  logic [31:0] wdata_a, wdata_b;
  logic        we_a, we_b, rsv_valid, rsv_ready;
  logic [6:0]  pending;

  // Second instance with ZFINX=1: the address MSB aliases onto the integer bank.
  logic [5:0]  z_raddr, z_waddr_a;
  logic [31:0] z_rdata, z_wdata_a;
  logic        z_we_a;
  logic [0:0]  z_rbusy;
  logic        z_rsv_ready;
  logic [6:0]  z_pending;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  riscv_register_file_sb #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .FPU(1), .ZFINX(0), .NUM_RPORTS(3)) dut (
    .clk(clk), .rst_n(rst_n), .setback_i(setback),
    .raddr_i(raddr), .rdata_o(rdata), .rbusy_o(rbusy),
    .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
    .waddr_b_i(waddr_b), .wdata_b_i(wdata_b), .we_b_i(we_b),
    .rsv_addr_i(rsv_addr), .rsv_valid_i(rsv_valid), .rsv_ready_o(rsv_ready),
    .pending_cnt_o(pending)
  );

  riscv_register_file_sb #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .FPU(1), .ZFINX(1), .NUM_RPORTS(1)) dut_z (
    .clk(clk), .rst_n(rst_n), .setback_i(1'b0),
    .raddr_i(z_raddr), .rdata_o(z_rdata), .rbusy_o(z_rbusy),
    .waddr_a_i(z_waddr_a), .wdata_a_i(z_wdata_a), .we_a_i(z_we_a),
    .waddr_b_i(6'd0), .wdata_b_i(32'd0), .we_b_i(1'b0),
    .rsv_addr_i(6'd0), .rsv_valid_i(1'b0), .rsv_ready_o(z_rsv_ready),
    .pending_cnt_o(z_pending)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then changed and outputs
  // sampled mid-cycle, well away from the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    we_a = 0; we_b = 0; rsv_valid = 0; setback = 0; z_we_a = 0;
  endtask

  function automatic logic [31:0] rd(input int k);
    logic [95:0] v;
    v = rdata;
    return v[k*32 +: 32];
  endfunction

  initial begin
    rst_n = 0; setback = 0; raddr = {3{6'd5}};
    waddr_a = 0; waddr_b = 0; rsv_addr = 0; wdata_a = 0; wdata_b = 0;
    we_a = 0; we_b = 0; rsv_valid = 0;
    z_raddr = 0; z_waddr_a = 0; z_wdata_a = 0; z_we_a = 0;

    // Reset: a reservation offered during reset is discarded.
    rsv_valid = 1; rsv_addr = 6'd5;
    tick(); tick();
    chk("rst_rdata0", rd(0), 32'h0);
    chk("rst_rdata2", rd(2), 32'h0);
    chk("rst_rbusy", {29'd0, rbusy}, 32'h0);
    chk("rst_pending", {25'd0, pending}, 32'h0);
    chk("rst_rsv_ready", {31'd0, rsv_ready}, 32'h1);
    rst_n = 1; rsv_valid = 0;
    #1;
    chk("rst_rsv_dropped", {29'd0, rbusy}, 32'h0);

    // Dual-write collision: port B wins.
    we_a = 1; waddr_a = 6'd7; wdata_a = 32'h1111_1111;
    we_b = 1; waddr_b = 6'd7; wdata_b = 32'h2222_2222;
    tick(); idle();
    raddr = {6'd0, 6'd0, 6'd7};
    #1 chk("collision_b_wins", rd(0), 32'h2222_2222);
    we_a = 1; waddr_a = 6'd0; wdata_a = 32'hDEAD_BEEF;
    tick(); idle();
    #1 chk("x0_reads_zero", rd(1), 32'h0);

    // Scoreboard reserve / refuse / release.
    raddr = {6'd0, 6'd0, 6'd10};
    rsv_valid = 1; rsv_addr = 6'd10;
    #1 chk("rsv_ready_free", {31'd0, rsv_ready}, 32'h1);
    tick(); idle();
    #1 chk("busy_after_rsv", {29'd0, rbusy}, 32'h1);
    chk("pending_1", {25'd0, pending}, 32'h1);
    rsv_valid = 1; rsv_addr = 6'd10;
    #1 chk("rsv_refused", {31'd0, rsv_ready}, 32'h0);
    tick(); idle();
    chk("pending_still_1", {25'd0, pending}, 32'h1);
    we_a = 1; waddr_a = 6'd10; wdata_a = 32'h5;
    tick(); idle();
    #1 chk("porta_keeps_busy", {29'd0, rbusy}, 32'h1);
    chk("porta_data", rd(0), 32'h5);
    we_b = 1; waddr_b = 6'd10; wdata_b = 32'hCAFE;
    tick(); idle();
    #1 chk("portb_clears_busy", {29'd0, rbusy}, 32'h0);
    chk("portb_data", rd(0), 32'hCAFE);
    chk("pending_0", {25'd0, pending}, 32'h0);

    // Write-back and reservation on the same free word: reservation survives.
    raddr = {6'd0, 6'd0, 6'd11};
    we_b = 1; waddr_b = 6'd11; wdata_b = 32'h99;
    rsv_valid = 1; rsv_addr = 6'd11;
    tick(); idle();
    #1 chk("wb_rsv_same_busy", {29'd0, rbusy}, 32'h1);
    chk("wb_rsv_same_data", rd(0), 32'h99);
    we_b = 1; waddr_b = 6'd11; wdata_b = 32'h9A;
    tick(); idle();
    #1 chk("wb_rsv_release", {25'd0, pending}, 32'h0);

    // Reserving x0 is accepted but has no effect.
    raddr = {6'd0, 6'd0, 6'd0};
    rsv_valid = 1; rsv_addr = 6'd0;
    #1 chk("rsv_x0_ready", {31'd0, rsv_ready}, 32'h1);
    tick(); idle();
    #1 chk("rsv_x0_not_busy", {29'd0, rbusy}, 32'h0);
    chk("rsv_x0_pending", {25'd0, pending}, 32'h0);

    // FP bank: FP word 0 is an ordinary register, integer x0 stays 0.
    we_a = 1; waddr_a = 6'h20; wdata_a = 32'hABCD;
    we_b = 1; waddr_b = 6'h00; wdata_b = 32'h1234;
    tick(); idle();
    raddr = {6'd0, 6'h00, 6'h20};
    #1 chk("fp_word0", rd(0), 32'hABCD);
    chk("int_x0_after_fp", rd(1), 32'h0);

    // ZFINX instance: address 0x25 aliases x5.
    z_we_a = 1; z_waddr_a = 6'h05; z_wdata_a = 32'h5A5A;
    tick(); idle();
    z_raddr = 6'h25;
    #1 chk("zfinx_alias", z_rdata, 32'h5A5A);

    // Setback mid-operation.
    rsv_valid = 1; rsv_addr = 6'd3;
    tick(); idle();
    rsv_valid = 1; rsv_addr = 6'd4;
    we_a = 1; waddr_a = 6'd9; wdata_a = 32'h55;
    tick(); idle();
    raddr = {6'd4, 6'd3, 6'd9};
    #1 chk("pre_setback_pending", {25'd0, pending}, 32'h2);
    chk("pre_setback_x9", rd(0), 32'h55);
    setback = 1; rsv_valid = 1; rsv_addr = 6'd6;
    we_b = 1; waddr_b = 6'd7; wdata_b = 32'h7777;
    tick(); idle();
    #1 chk("setback_x9", rd(0), 32'h0);
    chk("setback_busy", {29'd0, rbusy}, 32'h0);
    chk("setback_pending", {25'd0, pending}, 32'h0);
    raddr = {6'h20, 6'd6, 6'd7};
    #1 chk("setback_x7", rd(0), 32'h0);
    chk("setback_fp0", rd(2), 32'h0);
    chk("setback_x6_busy", {29'd0, rbusy}, 32'h0);

    // Same-cycle write-back to a busy word while reading it.
    we_a = 1; waddr_a = 6'd12; wdata_a = 32'h33;
    rsv_valid = 1; rsv_addr = 6'd12;
    tick(); idle();
    raddr = {6'd0, 6'd0, 6'd12};
    we_b = 1; waddr_b = 6'd12; wdata_b = 32'h77;
    #1;
`ifdef RF_WRITE_BYPASS_EN
    chk("bypass_data", rd(0), 32'h77);
    chk("bypass_busy", {29'd0, rbusy}, 32'h0);
`else
    chk("nobypass_data", rd(0), 32'h33);
    chk("nobypass_busy", {29'd0, rbusy}, 32'h1);
`endif
    tick(); idle();
    #1 chk("after_wb_data", rd(0), 32'h77);
    chk("after_wb_busy", {29'd0, rbusy}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
